// File: rtl/gray_rx.sv
// Gray-code receiver: decodes an up-counting Gray stream, checks each step
// against the previous value and tracks lock after LOCK_N clean advances.
module gray_rx #(
  parameter int WIDTH  = 3,
  parameter int LOCK_N = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] gray_in,
  output logic [WIDTH-1:0] bin_out,
  output logic             out_valid,
  output logic             step_err,
  output logic             locked,
  output logic [7:0]       err_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACQUIRE = 2'd1,
    ST_LOCKED  = 2'd2
  } state_t;

  localparam logic [3:0]       LP_LOCK = 4'(LOCK_N);
  localparam logic [WIDTH-1:0] LP_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

  state_t           r_state;
  state_t           w_state_next;
  logic [3:0]       r_run;
  logic [3:0]       w_run_next;
  logic [3:0]       w_run_inc;
  logic [WIDTH-1:0] r_ref;
  logic [WIDTH-1:0] r_bin;
  logic [WIDTH-1:0] w_bin;
  logic [WIDTH-1:0] w_ref_inc;
  logic             r_out_valid;
  logic             r_step_err;
  logic [7:0]       r_err_cnt;
  logic             w_adv;
  logic             w_hold;
  logic             w_err;

  // Each binary bit is the XOR of all Gray bits at or above it.
  assign w_bin[WIDTH-1] = gray_in[WIDTH-1];
  generate
    for (genvar gi = 0; gi < WIDTH - 1; gi++) begin : g_decode
      assign w_bin[gi] = ^gray_in[WIDTH-1:gi];
    end
  endgenerate

  assign w_ref_inc = r_ref + LP_ONE;
  assign w_run_inc = r_run + 4'd1;
  assign w_adv     = (w_bin == w_ref_inc);
  assign w_hold    = (w_bin == r_ref);

  always_comb begin
    w_state_next = r_state;
    w_run_next   = r_run;
    w_err        = 1'b0;
    if (in_valid) begin
      case (r_state)
        ST_IDLE: begin
          w_state_next = ST_ACQUIRE;
          w_run_next   = 4'd0;
        end
        ST_ACQUIRE: begin
          if (w_adv) begin
            w_run_next = w_run_inc;
            if (w_run_inc == LP_LOCK) w_state_next = ST_LOCKED;
          end else if (!w_hold) begin
            w_run_next = 4'd0;
            w_err      = 1'b1;
          end
        end
        ST_LOCKED: begin
          if (!w_adv && !w_hold) begin
            w_state_next = ST_ACQUIRE;
            w_run_next   = 4'd0;
            w_err        = 1'b1;
          end
        end
        default: begin
          w_state_next = ST_IDLE;
          w_run_next   = 4'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_run       <= 4'd0;
      r_ref       <= '0;
      r_bin       <= '0;
      r_out_valid <= 1'b0;
      r_step_err  <= 1'b0;
      r_err_cnt   <= 8'd0;
    end else begin
      r_state     <= w_state_next;
      r_run       <= w_run_next;
      r_out_valid <= in_valid;
      r_step_err  <= w_err;
      if (in_valid) begin
        r_ref <= w_bin;
        r_bin <= w_bin;
      end
      if (w_err && r_err_cnt != 8'hFF) r_err_cnt <= r_err_cnt + 8'd1;
    end
  end

  assign bin_out   = r_bin;
  assign out_valid = r_out_valid;
  assign step_err  = r_step_err;
  assign locked    = (r_state == ST_LOCKED);
  assign err_cnt   = r_err_cnt;

endmodule

// File: tb/tb_gray_rx.sv
// Bench for gray_rx: a sample-level reference model checked every cycle,
// plus directed vectors with hand-computed expectations.
module tb_gray_rx;

  localparam int W  = 3;
  localparam int LN = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         in_valid = 1'b0;
  logic [W-1:0] gray_in = '0;
  logic [W-1:0] bin_out;
  logic         out_valid;
  logic         step_err;
  logic         locked;
  logic [7:0]   err_cnt;

  int checks = 0;
  int errors = 0;

  gray_rx #(.WIDTH(W), .LOCK_N(LN)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .gray_in  (gray_in),
    .bin_out  (bin_out),
    .out_valid(out_valid),
    .step_err (step_err),
    .locked   (locked),
    .err_cnt  (err_cnt)
  );

  always #5 clk = ~clk;

  // Reference model: expected outputs after each clock edge.
  int  m_ref, m_run, m_errs;
  bit  m_have_ref, m_locked;
  int  e_bin, e_errs;
  bit  e_ov, e_step, e_locked;
  bit  chk_en = 1'b0;
  int  ov_cnt = 0;

  function automatic int g2b(input int g);
    int b = 0;
    for (int i = 0; i < W; i++) b = b ^ (g >> i);
    return b;
  endfunction

  always @(posedge clk) begin
    int b;
    if (rst) begin
      m_ref = 0; m_run = 0; m_errs = 0; m_have_ref = 0; m_locked = 0;
      e_bin = 0; e_ov = 0; e_step = 0;
    end else if (in_valid) begin
      b = g2b(int'(gray_in));
      e_ov = 1; e_bin = b; e_step = 0;
      if (!m_have_ref) begin
        m_have_ref = 1; m_run = 0;
      end else if (b == (m_ref + 1) % (1 << W)) begin
        if (!m_locked) begin
          m_run++;
          if (m_run == LN) m_locked = 1;
        end
      end else if (b != m_ref) begin
        e_step = 1; m_run = 0; m_locked = 0;
        if (m_errs < 255) m_errs++;
      end
      m_ref = b;
    end else begin
      e_ov = 0; e_step = 0;
    end
    e_locked = m_locked;
    e_errs   = m_errs;
  end

  task automatic cmp(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      cmp("model_out_valid", int'(out_valid), int'(e_ov));
      cmp("model_step_err", int'(step_err), int'(e_step));
      cmp("model_locked", int'(locked), int'(e_locked));
      cmp("model_err_cnt", int'(err_cnt), e_errs);
      cmp("model_bin_out", int'(bin_out), e_bin);
      if (out_valid) ov_cnt++;
    end
  end

  // Presents one sample, then idles for 'gap' cycles; returns on a negedge.
  task automatic send(input logic [W-1:0] g, input int gap);
    in_valid = 1'b1;
    gray_in  = g;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (gap) @(negedge clk);
    $display("sample gray=%b bin_out=%0d ov=%0d step_err=%0d locked=%0d err_cnt=%0d",
             g, bin_out, out_valid, step_err, locked, err_cnt);
  endtask

  logic [W-1:0] seq_a [5] = '{3'b000, 3'b001, 3'b011, 3'b010, 3'b110};
  logic [W-1:0] seq_b [5] = '{3'b111, 3'b101, 3'b100, 3'b000, 3'b001};
  logic [W-1:0] seq_c [4] = '{3'b111, 3'b101, 3'b100, 3'b000};
  int           bin_a [5] = '{0, 1, 2, 3, 4};
  int           bin_b [5] = '{5, 6, 7, 0, 1};

  initial begin
    int ov_before;
    @(negedge clk);
    // Reset for 2 cycles with a sample presented that must be discarded.
    rst = 1'b1; in_valid = 1'b1; gray_in = 3'b011;
    repeat (2) @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;
    chk_en = 1'b1;
    cmp("rst_bin_out", int'(bin_out), 0);
    cmp("rst_out_valid", int'(out_valid), 0);
    cmp("rst_step_err", int'(step_err), 0);
    cmp("rst_locked", int'(locked), 0);
    cmp("rst_err_cnt", int'(err_cnt), 0);
    @(negedge clk);

    for (int i = 0; i < 5; i++) begin
      send(seq_a[i], 0);
      cmp("acq_bin", int'(bin_out), bin_a[i]);
      cmp("acq_step_err", int'(step_err), 0);
      cmp("acq_locked", int'(locked), (i == 4) ? 1 : 0);
    end

    for (int i = 0; i < 5; i++) begin
      send(seq_b[i], 1);
      cmp("lock_bin", int'(bin_out), bin_b[i]);
      cmp("lock_step_err", int'(step_err), 0);
      cmp("lock_locked", int'(locked), 1);
    end

    send(3'b110, 0);
    cmp("inj_bin", int'(bin_out), 4);
    cmp("inj_step_err", int'(step_err), 1);
    cmp("inj_err_cnt", int'(err_cnt), 1);
    cmp("inj_locked", int'(locked), 0);
    for (int i = 0; i < 4; i++) begin
      send(seq_c[i], 0);
      cmp("relock_step_err", int'(step_err), 0);
      cmp("relock_locked", int'(locked), (i == 3) ? 1 : 0);
    end

    // Repeated code with gaps of 0..5 cycles.
    #1 ov_before = ov_cnt;
    for (int gap = 0; gap <= 5; gap++)
      for (int r = 0; r < 3; r++) begin
        send(3'b000, gap);
        cmp("hold_step_err", int'(step_err) | int'(out_valid & ~out_valid), 0);
        cmp("hold_locked", int'(locked), 1);
      end
    #1 cmp("hold_ov_pulses", ov_cnt - ov_before, 18);
    cmp("hold_err_cnt", int'(err_cnt), 1);

    for (int i = 0; i < 300; i++)
      send((i % 2 == 0) ? 3'b000 : 3'b110, 0);
    cmp("sat_err_cnt", int'(err_cnt), 255);
    cmp("sat_locked", int'(locked), 0);

    @(negedge clk);
    rst = 1'b1; in_valid = 1'b1; gray_in = 3'b001;
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;
    cmp("rst2_err_cnt", int'(err_cnt), 0);
    cmp("rst2_locked", int'(locked), 0);
    send(3'b110, 0);
    cmp("post_rst_step_err", int'(step_err), 0);
    cmp("post_rst_bin", int'(bin_out), 4);
    cmp("post_rst_err_cnt", int'(err_cnt), 0);
    send(3'b111, 2);
    cmp("post_rst_adv_bin", int'(bin_out), 5);
    cmp("post_rst_adv_step", int'(step_err), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
